muldiv_sequencer: RTL
=====================

# muldiv_sequencer

Multi-cycle multiply/divide sequencer for the pipelined MIPS core. It accepts MULT, MULTU, DIV and DIVU requests from the EX stage and iterates a shared shift-add / restoring-subtract datapath one bit per cycle. It owns the HI/LO registers and drives `busy`, which the hazard logic uses to stall the pipeline. It sits beside `ALU` in EX; `ALU` stays single-cycle and is not touched.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  request strobe; sampled only in IDLE.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `input1`  in  WIDTH  rs operand: multiplicand or dividend.
- `input2`  in  WIDTH  rt operand: multiplier or divisor.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse; HI/LO are valid in this cycle.
- `hi`  out  WIDTH  HI register: product upper half or remainder.
- `lo`  out  WIDTH  LO register: product lower half or quotient.
- `div_zero`  out  1  sticky until next accepted start; last DIV/DIVU had a zero divisor.

## Operation
- States: IDLE, RUN, FIX.
- `busy` = (state != IDLE).
- **IDLE**
  - When `start`=1, latch `op` and the operand magnitudes. For signed ops, take the absolute value; |-2^(WIDTH-1)| is held as an unsigned WIDTH-bit value.
  - Latch the result sign:
    - MULT: sign(a) XOR sign(b).
    - DIV quotient: same XOR.
    - DIV remainder: sign(a).
  - Clear `div_zero`, clear the iteration counter, go to RUN.
- **Divide by zero**
  - DIV/DIVU with `input2`==0 at start skips RUN.
  - On the same edge: `hi`←`input1`, `lo`←all ones, `div_zero`←1, `done`←1.
  - State stays IDLE and `busy` never rises.
- **RUN**
  - One iteration per edge for exactly `WIDTH` edges.
  - Multiply: 2*WIDTH-bit shift-add accumulator.
  - Divide: restoring shift/subtract giving WIDTH-bit quotient and remainder.
  - After the WIDTH-th iteration, go to FIX.
- **FIX**
  - Negate the results per the latched signs (two's complement).
  - Write `hi`/`lo`, pulse `done`, return to IDLE.
- Signed divide truncates toward zero; the remainder takes the dividend's sign.
- -2^(WIDTH-1) / -1 gives `lo`=0x80000000, `hi`=0. No trap.
- `hi`/`lo` change only on the `done` edge. They are never disturbed during RUN, so the pipeline may read stale HI/LO while `busy`.
- `start` while `busy` is ignored; no queueing. The pipeline holds the request via the `busy` stall.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, `div_zero`=0, counter=0.
- Let E0 be the start-accepting edge.
  - `busy`=1 after E0.
  - Iterations occur on edges E1..E`WIDTH`.
  - FIX occupies the cycle after E`WIDTH`. On E`WIDTH+1`, `hi`/`lo` are written and `done`=1 for exactly one cycle. `busy` falls on that same edge.
  - Total latency is 33 edges for WIDTH=32.
- Divide by zero: `done`=1 in the cycle immediately after E0.
- Back-to-back: `start` high in the `done` cycle is accepted, since state is IDLE. `done` falls while `busy` rises, and there are no idle bubbles.
- `reset` mid-operation aborts immediately. All outputs return to reset values and the partial result is discarded. The first edge after `reset` falls may accept `start`.
- Operand and `op` changes after E0 have no effect.

## Test plan
1. MULTU 0xFFFFFFFF × 0xFFFFFFFF.
   - `done` exactly 33 edges after the start edge.
   - `hi`=0xFFFFFFFE, `lo`=0x00000001.
   - `busy` high for 33 cycles.
2. MULT 0xFFFFFFFD (-3) × 7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. Then MULT 0x80000000 × 0x80000000 → `hi`=0x40000000, `lo`=0.
3. Divides:
   - DIVU 100 / 7 → `lo`=14, `hi`=2.
   - DIV 0xFFFFFFF9 (-7) / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
   - DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
4. DIV 0x12345678 / 0.
   - `done` in the next cycle, `busy` stays 0.
   - `hi`=0x12345678, `lo`=0xFFFFFFFF, `div_zero`=1.
   - A following MULTU 2×3 clears `div_zero` and gives `lo`=6.
5. Handshake.
   - Pulse `start` with MULTU 5×5 at cycles 3 and 10 of an in-flight DIVU 9/3. Both pulses are ignored; the DIVU result is `lo`=3, `hi`=0.
   - `start` with MULTU 5×5 held high in the `done` cycle is accepted. Its result (`lo`=25) appears 33 edges later.
6. Reset.
   - Assert `reset` asynchronously 10 cycles into a MULT. `busy`, `done`, `hi`, `lo` go to 0 without waiting for a clock edge.
   - After release, MULTU 6×7 completes normally with `lo`=42.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: one datapath bit per cycle,
// WIDTH+1 edges per operation, busy stalls the pipeline, start ignored while busy.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t             state;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH:0]     div_diff;
  logic               div_ok;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  assign busy = (state != IDLE);

  // Magnitudes are unsigned, so |-2^(WIDTH-1)| fits without overflow.
  always_comb begin
    sign_a = input1[WIDTH-1] & ~op[0];
    sign_b = input2[WIDTH-1] & ~op[0];
    abs_a  = sign_a ? (~input1 + 1'b1) : input1;
    abs_b  = sign_b ? (~input2 + 1'b1) : input2;
  end

  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, dividend bits / quotient bits}.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
    div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_trial - {1'b0, mag_b};
    div_ok    = ~div_diff[WIDTH];
    if (is_div) begin
      acc_next = {(div_ok ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0]),
                  acc[WIDTH-2:0], div_ok};
    end else begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod_neg = ~acc + 1'b1;
    if (is_div) begin
      fix_hi = neg_r ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
      fix_lo = neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    end else begin
      fix_hi = neg_q ? prod_neg[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      fix_lo = neg_q ? prod_neg[WIDTH-1:0] : acc[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      mag_a    <= '0;
      mag_b    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            div_zero <= 1'b0;
            cnt      <= '0;
            is_div   <= op[1];
            neg_q    <= sign_a ^ sign_b;
            neg_r    <= sign_a;
            mag_a    <= abs_a;
            mag_b    <= abs_b;
            acc      <= {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
            // Zero divisor resolves on the accepting edge and never raises busy.
            if (op[1] && (input2 == '0)) begin
              hi       <= input1;
              lo       <= '1;
              div_zero <= 1'b1;
              done     <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
